rv32_regfile: RTL and testbench
===============================

Name: rv32_regfile

Overview:
- RV32I integer register file for the decode stage: 32 x 32-bit registers, two combinational read ports, one synchronous write port.
- Writes come from the writeback stage.
- Includes same-cycle write-to-read bypass. The pipeline forwarding unit covers only EX and MEM results, so the WB hazard is resolved here.
- x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register and of the read/write data ports.
- NREGS, 32, number of architectural registers; must equal 2**AW.
- AW, 5, register index width.

Ports:
- clk  input  1  system clock, rising edge active.
- reset_n  input  1  asynchronous active-low reset.
- rs1  input  AW  read port 1 register index.
- rdata1  output  XLEN  read port 1 data, combinational.
- rs2  input  AW  read port 2 register index.
- rdata2  output  XLEN  read port 2 data, combinational.
- wreg  input  AW  write register index.
- wdata  input  XLEN  write data.
- wen  input  1  write enable, sampled on rising clk.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset: asserting reset_n=0 immediately clears all registers to 0, independent of clk. While in reset, rdata1/rdata2 = 0 except through the bypass (see below).
- Write: on rising clk with reset_n=1, wen=1 and wreg!=0, reg[wreg] <= wdata.
  - wen=0: no state change.
  - wreg=0: write is discarded; x0 always reads 0.
- Read: rdataN is a pure combinational function of rsN, stored state and the bypass inputs; zero latency.
  - rsN==0 -> 0, always, even if wen=1 and wreg=0.
  - Bypass (write-first): rsN!=0, wen=1 and wreg==rsN -> rdataN = wdata in the same cycle, before the clock edge commits it.
  - Otherwise rdataN = reg[rsN].
- Both ports are independent. rs1==rs2 is legal and both ports return identical data, including bypass.
- Simultaneous events:
  - Write and read of the same index in one cycle returns the new data (bypass); after the edge, stored data equals that value.
  - Reset deasserting on the same edge as a write: the write is not required to take effect; the bench must not depend on it.
  - Reset asserted mid-operation clears state regardless of a pending wen.
- No X propagation: every index 0..NREGS-1 is valid, so no out-of-range case exists.

Decomposition:
- Shared package holds XLEN and AW (register index width); the pipeline stages also use these.
- No sub-modules. The storage array, write logic and two identical read/bypass muxes are in one module.
- The read-port mux plus bypass is written once and replicated per port (generate or function).

Test Plan:
- Reset: write x5=0xDEADBEEF, then pulse reset_n=0 asynchronously between edges -> rdata1 for rs1=5 reads 0 immediately, and still 0 after reset release.
- Basic write/read: write x1=0x12345678 and x31=0xFFFFFFFF on successive edges with wen=1 -> rs1=1 and rs2=31 read 0x12345678 and 0xFFFFFFFF; other registers read 0.
- x0 hardwire: wen=1, wreg=0, wdata=0xAAAA5555 -> rs1=0 reads 0 in the same cycle (no bypass) and after the edge.
- Bypass: x7 holds 0x11111111; in one cycle wen=1, wreg=7, wdata=0x22222222, rs1=rs2=7 -> both read 0x22222222 before the edge; after the edge with wen=0, both still read 0x22222222.
- Write disable: wen=0, wreg=3, wdata=0x55 for several edges -> rs2=3 remains 0; with rs1=3 and wreg=4, wen=1 -> rdata1 unaffected (no false bypass).
- Random: 10k cycles of random rs1/rs2/wreg/wdata/wen checked against a reference model with write-first semantics and x0=0.

Source files
------------

// File: rtl/rv32_regfile_pkg.sv
// rtl/rv32_regfile_pkg.sv - shared RV32I datapath widths used by decode and the pipeline stages
package rv32_regfile_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 1 << AW;

    typedef logic [XLEN-1:0] xlen_t;
    typedef logic [AW-1:0]   reg_idx_t;

endpackage

// File: rtl/rv32_regfile.sv
// rtl/rv32_regfile.sv - RV32I integer register file, two combinational read ports with WB bypass
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset, clears every register
//   rs1 / rdata1   read port 1 index / data (combinational)
//   rs2 / rdata2   read port 2 index / data (combinational)
//   wreg / wdata   writeback index / data
//   wen            writeback enable, sampled on rising clk
module rv32_regfile #(
    parameter int XLEN  = rv32_regfile_pkg::XLEN,
    parameter int NREGS = rv32_regfile_pkg::NREGS,
    parameter int AW    = rv32_regfile_pkg::AW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rdata2,
    input  logic [AW-1:0]   wreg,
    input  logic [XLEN-1:0] wdata,
    input  logic            wen
);

    logic [XLEN-1:0] regs [NREGS];

    // Entry 0 is never written, so it stays at its reset value; reads of x0
    // are additionally forced to zero in the read mux.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (wreg != '0)) begin
            regs[wreg] <= wdata;
        end
    end

    // Write-first read: the WB stage is not covered by the forwarding unit, so
    // an in-flight write to the same index is returned before it commits.
    // The bypass is purely combinational and therefore also active in reset.
    function automatic logic [XLEN-1:0] read_mux(
        input logic [AW-1:0]   rs,
        input logic [XLEN-1:0] stored,
        input logic            we,
        input logic [AW-1:0]   wr,
        input logic [XLEN-1:0] wd
    );
        if (rs == '0) begin
            return '0;
        end else if (we && (wr == rs)) begin
            return wd;
        end else begin
            return stored;
        end
    endfunction

    assign rdata1 = read_mux(rs1, regs[rs1], wen, wreg, wdata);
    assign rdata2 = read_mux(rs2, regs[rs2], wen, wreg, wdata);

endmodule

// File: tb/tb_rv32_regfile.sv
// tb/tb_rv32_regfile.sv - self-checking bench for rv32_regfile
module tb_rv32_regfile;
    import rv32_regfile_pkg::*;

    logic            clk;
    logic            reset_n;
    logic [AW-1:0]   rs1;
    logic [XLEN-1:0] rdata1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rdata2;
    logic [AW-1:0]   wreg;
    logic [XLEN-1:0] wdata;
    logic            wen;

    int checks = 0;
    int errors = 0;

    // Architectural state as the bench believes it to be.
    logic [XLEN-1:0] model [NREGS];

    rv32_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rs1     (rs1),
        .rdata1  (rdata1),
        .rs2     (rs2),
        .rdata2  (rdata2),
        .wreg    (wreg),
        .wdata   (wdata),
        .wen     (wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value: x0 is zero, a same-cycle write to the index wins,
    // otherwise the architectural value.
    function automatic logic [XLEN-1:0] ref_read(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        if (wen && wreg == rs) return wdata;
        return model[rs];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    task automatic drive(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] w, input logic [XLEN-1:0] d, input logic e);
        rs1 = a1; rs2 = a2; wreg = w; wdata = d; wen = e;
        #1;
    endtask

    // Commit one rising edge into the model, then return to the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset_n && wen && wreg != 0) model[wreg] = wdata;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        rs1 = 5; rs2 = 31; wreg = 0; wdata = '0; wen = 1'b0;
        model_reset();
        #1;
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_rdata2", rdata2, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset between edges
        drive(5, 0, 5, 32'hDEADBEEF, 1'b1);
        cycle();
        drive(5, 0, 0, 32'h0, 1'b0);
        check("pre_reset_x5", rdata1, 32'hDEADBEEF);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_x5", rdata1, 32'h0);
        #1 reset_n = 1'b1;
        #1;
        check("post_reset_x5", rdata1, 32'h0);
        @(negedge clk);

        // Reset held across an edge with a pending write: write is dropped,
        // but the combinational bypass still shows the pending data.
        drive(0, 9, 9, 32'hCAFEF00D, 1'b1);
        check("bypass_pre_reset", rdata2, 32'hCAFEF00D);
        reset_n = 1'b0;
        #1;
        check("bypass_in_reset", rdata2, 32'hCAFEF00D);
        cycle();
        wen = 1'b0;
        reset_n = 1'b1;
        #1;
        check("reset_drops_write", rdata2, 32'h0);

        // Basic write/read
        drive(0, 0, 1, 32'h12345678, 1'b1);
        cycle();
        drive(0, 0, 31, 32'hFFFFFFFF, 1'b1);
        cycle();
        drive(1, 31, 0, 32'h0, 1'b0);
        check("basic_x1", rdata1, 32'h12345678);
        check("basic_x31", rdata2, 32'hFFFFFFFF);
        for (int r = 2; r < 31; r++) begin
            drive(AW'(r), AW'(r), 0, 32'h0, 1'b0);
            check("basic_others_p1", rdata1, 32'h0);
            check("basic_others_p2", rdata2, 32'h0);
        end

        // x0 hardwire
        drive(0, 0, 0, 32'hAAAA5555, 1'b1);
        check("x0_same_cycle_p1", rdata1, 32'h0);
        check("x0_same_cycle_p2", rdata2, 32'h0);
        cycle();
        drive(0, 0, 0, 32'h0, 1'b0);
        check("x0_after_edge", rdata1, 32'h0);

        // Bypass on both ports at once
        drive(0, 0, 7, 32'h11111111, 1'b1);
        cycle();
        drive(7, 7, 7, 32'h22222222, 1'b1);
        check("bypass_p1", rdata1, 32'h22222222);
        check("bypass_p2", rdata2, 32'h22222222);
        cycle();
        drive(7, 7, 0, 32'h0, 1'b0);
        check("bypass_commit_p1", rdata1, 32'h22222222);
        check("bypass_commit_p2", rdata2, 32'h22222222);

        // Write disable
        for (int k = 0; k < 3; k++) begin
            drive(0, 3, 3, 32'h55, 1'b0);
            check("wen_low_same_cycle", rdata2, 32'h0);
            cycle();
        end
        drive(0, 3, 0, 32'h0, 1'b0);
        check("wen_low_after", rdata2, 32'h0);
        drive(3, 0, 4, 32'h99, 1'b1);
        check("no_false_bypass", rdata1, 32'h0);
        cycle();
        drive(4, 3, 0, 32'h0, 1'b0);
        check("x4_written", rdata1, 32'h99);
        check("x3_untouched", rdata2, 32'h0);

        // Randomized traffic, biased toward index collisions
        for (int n = 0; n < 10000; n++) begin
            logic [AW-1:0]   w;
            logic [AW-1:0]   a1;
            logic [AW-1:0]   a2;
            w  = AW'($urandom_range(0, NREGS - 1));
            a1 = ($urandom_range(0, 3) == 0) ? w : AW'($urandom_range(0, NREGS - 1));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, NREGS - 1));
            drive(a1, a2, w, XLEN'($urandom), 1'($urandom_range(0, 1)));
            check("rand_p1", rdata1, ref_read(rs1));
            check("rand_p2", rdata2, ref_read(rs2));
            cycle();
        end

        // Final sweep of stored state
        for (int r = 0; r < NREGS; r++) begin
            drive(AW'(r), AW'(NREGS - 1 - r), 0, 32'h0, 1'b0);
            check("sweep_p1", rdata1, (r == 0) ? 32'h0 : model[r]);
            check("sweep_p2", rdata2, (r == NREGS - 1) ? 32'h0 : model[NREGS - 1 - r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
